regwrite_decoder_sb: RTL and testbench

- Parametrised write-port decoder for the register file, generalised from the fixed 2:4 / 5:32 enable-decoder tree.
- Produces a one-hot write-enable vector from a write address gated by RegWrite.
- Adds a registered pending-write scoreboard:
  - an instruction issuing a write marks its destination busy;
  - the matching writeback decode clears it.
- Sits between the pipeline control and the register file. The hazard unit uses the busy outputs to stall.

---
 rtl/regwrite_decoder_sb.sv | 105 ++++++++++
 tb/tb_regwrite_decoder_sb.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/regwrite_decoder_sb.sv
`default_nettype none
// ============================================================================
//  Module   : regwrite_decoder_sb
//  Purpose  : Register-file write-port decoder with a pending-write
//             scoreboard. It turns the writeback address into one-hot write
//             enables, tracks in-flight destinations, and exposes busy flags
//             for the hazard unit.
//  Options  : REGWRITE_ZERO_REG_EN - ZERO_REG becomes a hardwired-zero
//             register. It is never written and never marked pending.
//  Revision : 1.0 - initial release
// ============================================================================
module regwrite_decoder_sb #(
  parameter  int ADDR_W   = 5,
  parameter  int ZERO_REG = 31,
  parameter  int CNT_W    = ADDR_W + 1,
  localparam int NUM_REGS = 2**ADDR_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                RegWrite,
  input  logic [ADDR_W-1:0]   select,
  output logic [NUM_REGS-1:0] enabler,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_reg,
  output logic                issue_ready,
  input  logic [ADDR_W-1:0]   rd_a,
  input  logic [ADDR_W-1:0]   rd_b,
  output logic                busy_a,
  output logic                busy_b,
  output logic [NUM_REGS-1:0] pending,
  output logic [CNT_W-1:0]    pend_cnt
);

`ifdef REGWRITE_ZERO_REG_EN
  localparam bit c_zero_en = 1'b1;
`else
  localparam bit c_zero_en = 1'b0;
`endif

  // Bits excluded from writes and from scoreboard tracking.
  localparam logic [NUM_REGS-1:0] c_zero_mask =
    c_zero_en ? (NUM_REGS'(1) << ZERO_REG) : '0;

  logic [NUM_REGS-1:0] w_sel_hit;
  logic [NUM_REGS-1:0] w_iss_hit;
  logic [NUM_REGS-1:0] w_wb_clr;
  logic [NUM_REGS-1:0] w_issue_set;
  logic [NUM_REGS-1:0] w_pending_nxt;
  logic                w_accept;
  logic                w_set_new;
  logic                w_clr_old;

  logic [NUM_REGS-1:0] r_pending;
  logic [CNT_W-1:0]    r_cnt;

  // One address comparator per register for the writeback and issue indices.
  generate
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_dec
      assign w_sel_hit[i] = (select    == ADDR_W'(i));
      assign w_iss_hit[i] = (issue_reg == ADDR_W'(i));
    end
  endgenerate

  // Writeback enables: gated by RegWrite, suppressed during reset.
  always_comb begin
    w_wb_clr = '0;
    if (RegWrite && !reset) begin
      w_wb_clr = w_sel_hit & ~c_zero_mask;
    end
  end

  assign enabler = w_wb_clr;

  // A WAW on an in-flight register stalls, unless that register retires now.
  assign issue_ready = !reset && (!r_pending[issue_reg] || w_wb_clr[issue_reg]);
  assign w_accept    = issue_valid && issue_ready;
  assign w_issue_set = w_accept ? (w_iss_hit & ~c_zero_mask) : '0;

  // Set wins over a same-cycle clear on the same register.
  assign w_pending_nxt = (r_pending & ~w_wb_clr) | w_issue_set;

  // At most one bit can rise and one can fall per cycle, so single flags suffice.
  assign w_set_new = |(w_issue_set & ~r_pending);
  assign w_clr_old = |(w_wb_clr & r_pending & ~w_issue_set);

  // Same-cycle writeback forwards, so a reader of a retiring register is not busy.
  assign busy_a = r_pending[rd_a] & ~w_wb_clr[rd_a];
  assign busy_b = r_pending[rd_b] & ~w_wb_clr[rd_b];

  // Scoreboard and its population count advance together every edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= '0;
      r_cnt     <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      r_cnt     <= r_cnt + CNT_W'(w_set_new) - CNT_W'(w_clr_old);
    end
  end

  assign pending  = r_pending;
  assign pend_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_regwrite_decoder_sb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regwrite_decoder_sb
//  Purpose  : Directed scoreboard bench for regwrite_decoder_sb (defaults).
//             Honours REGWRITE_ZERO_REG_EN when defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regwrite_decoder_sb;

`ifdef REGWRITE_ZERO_REG_EN
  localparam logic [31:0] c_zm = 32'h8000_0000;
`else
  localparam logic [31:0] c_zm = 32'h0000_0000;
`endif

  logic        clk;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  select;
  logic [31:0] enabler;
  logic        issue_valid;
  logic [4:0]  issue_reg;
  logic        issue_ready;
  logic [4:0]  rd_a;
  logic [4:0]  rd_b;
  logic        busy_a;
  logic        busy_b;
  logic [31:0] pending;
  logic [5:0]  pend_cnt;

  regwrite_decoder_sb dut (
    .clk         (clk),
    .reset       (reset),
    .RegWrite    (RegWrite),
    .select      (select),
    .enabler     (enabler),
    .issue_valid (issue_valid),
    .issue_reg   (issue_reg),
    .issue_ready (issue_ready),
    .rd_a        (rd_a),
    .rd_b        (rd_b),
    .busy_a      (busy_a),
    .busy_b      (busy_b),
    .pending     (pending),
    .pend_cnt    (pend_cnt)
  );

  typedef struct {
    string       name;
    logic [31:0] en;
    logic        rdy;
    logic        ba;
    logic        bb;
    logic [31:0] pend;
    logic [5:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s got %h expected %h", nm, fld, act, req);
    end
  endtask

  // Monitor: the DUT presents a response every cycle; sample mid low phase.
  always begin
    @(negedge clk);
    #3;
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.name, "enabler",     enabler,             e.en);
      chk(e.name, "issue_ready", {31'd0, issue_ready}, {31'd0, e.rdy});
      chk(e.name, "busy_a",      {31'd0, busy_a},     {31'd0, e.ba});
      chk(e.name, "busy_b",      {31'd0, busy_b},     {31'd0, e.bb});
      chk(e.name, "pending",     pending,             e.pend);
      chk(e.name, "pend_cnt",    {26'd0, pend_cnt},   {26'd0, e.cnt});
    end
  end

  // Driver: apply one cycle of inputs and queue the hand-computed response.
  task automatic vec(input string nm, input logic rst_i, input logic rw, input logic [4:0] sel,
                     input logic iv, input logic [4:0] ir, input logic [4:0] ra, input logic [4:0] rb,
                     input logic [31:0] e_en, input logic e_rdy, input logic e_ba, input logic e_bb,
                     input logic [31:0] e_pend, input logic [5:0] e_cnt);
    exp_t e;
    @(negedge clk);
    reset = rst_i; RegWrite = rw; select = sel;
    issue_valid = iv; issue_reg = ir; rd_a = ra; rd_b = rb;
    e.name = nm; e.en = e_en; e.rdy = e_rdy; e.ba = e_ba; e.bb = e_bb;
    e.pend = e_pend; e.cnt = e_cnt;
    exp_q.push_back(e);
  endtask

  initial begin
    logic [31:0] m;
    logic [31:0] one;
    reset = 1'b1; RegWrite = 1'b0; select = '0;
    issue_valid = 1'b0; issue_reg = '0; rd_a = '0; rd_b = '0;
    repeat (2) @(posedge clk);

    // Reset state: outputs suppressed, scoreboard empty
    vec("reset", 1, 1, 3, 1, 2, 0, 0, 32'h0, 0, 0, 0, 32'h0, 6'd0);

    // Decoder sweep with RegWrite high
    for (int s = 0; s < 32; s++) begin
      one = 32'h1 << s;
      vec("dec_on", 0, 1, 5'(s), 0, 0, 0, 0, one & ~c_zm, 1, 0, 0, 32'h0, 6'd0);
    end
    // RegWrite low: no enable at all
    vec("dec_off0",  0, 0, 0,  0, 0, 0, 0, 32'h0, 1, 0, 0, 32'h0, 6'd0);
    vec("dec_off5",  0, 0, 5,  0, 0, 0, 0, 32'h0, 1, 0, 0, 32'h0, 6'd0);
    vec("dec_off31", 0, 0, 31, 0, 0, 0, 0, 32'h0, 1, 0, 0, 32'h0, 6'd0);

    // Issue then retire register 5
    vec("iss5",     0, 0, 0, 1, 5, 5, 6, 32'h0,       1, 0, 0, 32'h0,       6'd0);
    vec("pend5_a",  0, 0, 0, 0, 0, 5, 6, 32'h0,       1, 1, 0, 32'h0000_0020, 6'd1);
    vec("pend5_b",  0, 0, 0, 0, 0, 5, 6, 32'h0,       1, 1, 0, 32'h0000_0020, 6'd1);
    vec("wb5",      0, 1, 5, 0, 0, 5, 5, 32'h0000_0020, 1, 0, 0, 32'h0000_0020, 6'd1);
    vec("clr5",     0, 0, 0, 0, 0, 5, 5, 32'h0,       1, 0, 0, 32'h0,       6'd0);

    // WAW stall on register 7, released by a same-cycle writeback
    vec("iss7",     0, 0, 0, 1, 7, 0, 0, 32'h0,       1, 0, 0, 32'h0,       6'd0);
    vec("waw7_a",   0, 0, 0, 1, 7, 7, 0, 32'h0,       0, 1, 0, 32'h0000_0080, 6'd1);
    vec("waw7_b",   0, 0, 0, 1, 7, 7, 0, 32'h0,       0, 1, 0, 32'h0000_0080, 6'd1);
    vec("waw7_wb",  0, 1, 7, 1, 7, 7, 0, 32'h0000_0080, 1, 0, 0, 32'h0000_0080, 6'd1);
    vec("keep7",    0, 0, 0, 0, 0, 7, 0, 32'h0,       1, 1, 0, 32'h0000_0080, 6'd1);
    vec("wb7",      0, 1, 7, 0, 0, 7, 0, 32'h0000_0080, 1, 0, 0, 32'h0000_0080, 6'd1);

    // Concurrent issue 9 and writeback 3
    vec("iss3",     0, 0, 0, 1, 3, 0, 0, 32'h0,       1, 0, 0, 32'h0,       6'd0);
    vec("i9_wb3",   0, 1, 3, 1, 9, 3, 9, 32'h0000_0008, 1, 0, 0, 32'h0000_0008, 6'd1);
    vec("only9",    0, 0, 0, 0, 0, 3, 9, 32'h0,       1, 0, 1, 32'h0000_0200, 6'd1);

    // Build {1,2,4} then reset mid-operation
    vec("wb9_i1",   0, 1, 9, 1, 1, 0, 0, 32'h0000_0200, 1, 0, 0, 32'h0000_0200, 6'd1);
    vec("iss2",     0, 0, 0, 1, 2, 0, 0, 32'h0,       1, 0, 0, 32'h0000_0002, 6'd1);
    vec("iss4",     0, 0, 0, 1, 4, 0, 0, 32'h0,       1, 0, 0, 32'h0000_0006, 6'd2);
    vec("p124",     0, 0, 0, 0, 0, 1, 4, 32'h0,       1, 1, 1, 32'h0000_0016, 6'd3);
    vec("rst_mid",  1, 1, 1, 1, 8, 1, 4, 32'h0,       0, 1, 1, 32'h0000_0016, 6'd3);
    vec("post_rst", 0, 1, 1, 0, 0, 1, 2, 32'h0000_0002, 1, 0, 0, 32'h0,       6'd0);
    vec("post_wb",  0, 0, 0, 0, 0, 1, 2, 32'h0,       1, 0, 0, 32'h0,       6'd0);

    // Register 31: ordinary by default, hardwired zero with the option
    vec("z_iss",    0, 1, 31, 1, 31, 31, 0, 32'h8000_0000 & ~c_zm, 1, 0, 0, 32'h0, 6'd0);
    vec("z_pend",   0, 0, 0, 0, 0, 31, 31, 32'h0, 1, (c_zm == 0), (c_zm == 0),
        32'h8000_0000 & ~c_zm, (c_zm == 0) ? 6'd1 : 6'd0);
    vec("z_waw",    0, 0, 0, 1, 31, 0, 0, 32'h0, (c_zm != 0), 0, 0,
        32'h8000_0000 & ~c_zm, (c_zm == 0) ? 6'd1 : 6'd0);
    vec("z_wb",     0, 1, 31, 0, 0, 31, 0, 32'h8000_0000 & ~c_zm, 1, 0, 0,
        32'h8000_0000 & ~c_zm, (c_zm == 0) ? 6'd1 : 6'd0);
    vec("z_clr",    0, 0, 0, 0, 0, 31, 0, 32'h0, 1, 0, 0, 32'h0, 6'd0);

    // Fill every register: the counter must reach NUM_REGS without wrapping
    for (int i = 0; i < 32; i++) begin
      m = ((32'h1 << i) - 32'h1) & ~c_zm;
      vec("fill", 0, 0, 0, 1, 5'(i), 5'(i), 0, 32'h0, 1, 0, (i > 0), m, 6'($countones(m)));
    end
    m = ~c_zm;
    vec("full", 0, 0, 0, 0, 0, 0, 31, 32'h0, 0, 1, (c_zm == 0), m, 6'($countones(m)));

    // Drain every register
    for (int i = 0; i < 32; i++) begin
      m = ~((32'h1 << i) - 32'h1) & ~c_zm;
      one = (32'h1 << i) & ~c_zm;
      vec("drain", 0, 1, 5'(i), 0, 0, 5'(i), 31, one, 1, 0, (c_zm == 0) && (i < 31),
          m, 6'($countones(m)));
    end
    vec("empty", 0, 0, 0, 0, 0, 0, 31, 32'h0, 1, 0, 0, 32'h0, 6'd0);

    // Let the monitor consume the tail of the queue, bounded
    for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(posedge clk);
    @(negedge clk);
    #5;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_queue left %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
